leaf_stream_fifo: RTL and testbench



---
 rtl/leaf_stream_fifo.sv | 103 ++++++++++
 tb/tb_leaf_stream_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_fifo.sv
// Leaf streaming buffer: FWFT circular FIFO with sequence tagging, a registered
// output stage, occupancy and saturating delivered-beat statistics.
module leaf_stream_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SEQ_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       beats_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               out_valid_q, out_valid_d;
  entry_t             out_entry_q, out_entry_d;
  logic               push, pop;

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = out_valid_q;
  assign out_data  = out_entry_q.data;
  assign out_seq   = out_entry_q.seq;
  assign level     = level_q;
  assign beats_out = beats_q;

  always_comb begin
    push        = in_valid && in_ready;
    pop         = out_valid_q && out_ready;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    seq_cnt_d   = seq_cnt_q + SEQ_W'(push);
    beats_d     = beats_q;
    out_valid_d = (level_d != '0);
    out_entry_d = out_entry_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: in_data, seq: seq_cnt_q};
    end
    if (pop && (beats_q != '1)) begin
      beats_d = beats_q + CNT_W'(1);
    end

    // When the only remaining beat is the one being written this cycle, the
    // head comes from the input rather than the not-yet-updated storage.
    if (level_d != '0) begin
      if (push && (level_q == LVL_W'(pop))) begin
        out_entry_d = '{data: in_data, seq: seq_cnt_q};
      end else begin
        out_entry_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      seq_cnt_q   <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      seq_cnt_q   <= seq_cnt_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  // Storage contents are don't-care while not counted by level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Directed self-checking bench for leaf_stream_fifo (DEPTH=4, CNT_W=8).
module tb_leaf_stream_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [7:0] out_seq;
  logic [2:0] level;
  logic [7:0] beats_out;

  int checks = 0;
  int passed = 0;

  leaf_stream_fifo #(
    .DATA_W(8),
    .DEPTH (4),
    .SEQ_W (8),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_seq  (out_seq),
    .level    (level),
    .beats_out(beats_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic push_beat(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
    checks++; if (beats_out !== 8'd0) $display("FAIL reset_beats got=%0d exp=0", beats_out); else passed++;
    checks++; if (out_seq !== 8'd0) $display("FAIL reset_out_seq got=%0d exp=0", out_seq); else passed++;
    checks++; if (out_data !== 8'd0) $display("FAIL reset_out_data got=%h exp=00", out_data); else passed++;
  endtask

  task automatic test_single_beat();
    apply_reset();
    out_ready = 1'b1;
    push_beat(8'hA5);
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else passed++;
    checks++; if (out_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", out_data); else passed++;
    checks++; if (out_seq !== 8'd0) $display("FAIL single_seq got=%0d exp=0", out_seq); else passed++;
    checks++; if (level !== 3'd1) $display("FAIL single_level1 got=%0d exp=1", level); else passed++;
    checks++; if (beats_out !== 8'd0) $display("FAIL single_beats0 got=%0d exp=0", beats_out); else passed++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_after got=%b exp=0", out_valid); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL single_level0 got=%0d exp=0", level); else passed++;
    checks++; if (beats_out !== 8'd1) $display("FAIL single_beats1 got=%0d exp=1", beats_out); else passed++;
    step();
    checks++; if (beats_out !== 8'd1) $display("FAIL empty_pop_beats got=%0d exp=1", beats_out); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL empty_pop_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_fill_backpressure();
    logic pushed;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_beat(8'(i));
    checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else passed++;
    checks++; if (level !== 3'd4) $display("FAIL full_level got=%0d exp=4", level); else passed++;
    in_valid = 1'b1; in_data = 8'h05;
    step();
    checks++; if (level !== 3'd4) $display("FAIL full_ignored_level got=%0d exp=4", level); else passed++;
    checks++; if (out_data !== 8'h01) $display("FAIL full_hold_data got=%h exp=01", out_data); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid k=%0d got=%b exp=1", k, out_valid); else passed++;
      checks++; if (out_data !== 8'(k + 1)) $display("FAIL drain_data k=%0d got=%h exp=%h", k, out_data, 8'(k + 1)); else passed++;
      checks++; if (out_seq !== 8'(k)) $display("FAIL drain_seq k=%0d got=%0d exp=%0d", k, out_seq, k); else passed++;
      if (k == 0) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL drain_ready0 got=%b exp=0", in_ready); else passed++;
      end
      if (k == 1) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL drain_ready1 got=%b exp=1", in_ready); else passed++;
      end
      pushed = in_valid && in_ready;
      step();
      if (pushed) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL drain_end_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL drain_end_level got=%0d exp=0", level); else passed++;
    checks++; if (beats_out !== 8'd5) $display("FAIL drain_end_beats got=%0d exp=5", beats_out); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_beat(8'h10);
    push_beat(8'h11);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h12 + i); out_ready = 1'b1;
      checks++; if (level !== 3'd2) $display("FAIL b2b_level i=%0d got=%0d exp=2", i, level); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); else passed++;
      checks++; if (out_data !== 8'(8'h10 + i)) $display("FAIL b2b_data i=%0d got=%h exp=%h", i, out_data, 8'(8'h10 + i)); else passed++;
      checks++; if (out_seq !== 8'(i)) $display("FAIL b2b_seq i=%0d got=%0d exp=%0d", i, out_seq, i); else passed++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (level !== 3'd2) $display("FAIL b2b_end_level got=%0d exp=2", level); else passed++;
    for (int j = 0; j < 2; j++) begin
      checks++; if (out_data !== 8'(8'h1A + j)) $display("FAIL b2b_tail_data j=%0d got=%h exp=%h", j, out_data, 8'(8'h1A + j)); else passed++;
      checks++; if (out_seq !== 8'(10 + j)) $display("FAIL b2b_tail_seq j=%0d got=%0d exp=%0d", j, out_seq, 10 + j); else passed++;
      step();
    end
    checks++; if (level !== 3'd0) $display("FAIL b2b_drained got=%0d exp=0", level); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_saturate();
    int   pushes;
    int   pops;
    logic do_pop;
    logic do_push;
    apply_reset();
    pushes = 0; pops = 0;
    in_valid = 1'b1; in_data = 8'd0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && pops < 300; cyc++) begin
      checks++;
      if (beats_out !== 8'((pops > 255) ? 255 : pops))
        $display("FAIL sat_beats pops=%0d got=%0d exp=%0d", pops, beats_out, (pops > 255) ? 255 : pops);
      else passed++;
      do_pop  = out_valid;
      do_push = in_valid && in_ready;
      if (do_pop) begin
        checks++; if (out_seq !== 8'(pops)) $display("FAIL wrap_seq n=%0d got=%0d exp=%0d", pops, out_seq, 8'(pops)); else passed++;
        checks++; if (out_data !== 8'(pops)) $display("FAIL wrap_data n=%0d got=%h exp=%h", pops, out_data, 8'(pops)); else passed++;
      end
      step();
      if (do_push) pushes++;
      if (do_pop) pops++;
      in_valid = (pushes < 300);
      in_data  = 8'(pushes);
    end
    checks++; if (pops != 300) $display("FAIL wrap_timeout got=%0d exp=300", pops); else passed++;
    checks++; if (beats_out !== 8'd255) $display("FAIL sat_final got=%0d exp=255", beats_out); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL wrap_level got=%0d exp=0", level); else passed++;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push_beat(8'h31);
    push_beat(8'h32);
    push_beat(8'h33);
    checks++; if (level !== 3'd3) $display("FAIL mid_level3 got=%0d exp=3", level); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL mid_valid1 got=%b exp=1", out_valid); else passed++;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL mid_rst_level got=%0d exp=0", level); else passed++;
    checks++; if (out_data !== 8'd0) $display("FAIL mid_rst_data got=%h exp=00", out_data); else passed++;
    checks++; if (beats_out !== 8'd0) $display("FAIL mid_rst_beats got=%0d exp=0", beats_out); else passed++;
    push_beat(8'h44);
    checks++; if (out_valid !== 1'b1) $display("FAIL mid_new_valid got=%b exp=1", out_valid); else passed++;
    checks++; if (out_data !== 8'h44) $display("FAIL mid_new_data got=%h exp=44", out_data); else passed++;
    checks++; if (out_seq !== 8'd0) $display("FAIL mid_new_seq got=%0d exp=0", out_seq); else passed++;
    checks++; if (level !== 3'd1) $display("FAIL mid_new_level got=%0d exp=1", level); else passed++;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_stale_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL mid_final_level got=%0d exp=0", level); else passed++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_stale_valid2 got=%b exp=0", out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill_backpressure();
    test_back_to_back();
    test_wrap_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
